// File: rtl/y_wb_pkg.sv
// Shared widths, lane layout, FSM state encoding and select check for the Y writeback merge stage.
// Optional feature macro: Y_WB_COALESCE_EN (adds a one-word coalesce buffer and the EVICT state).
package y_wb_pkg;

    localparam int unsigned Y_ADDR_W = 11;
    localparam int unsigned LANES    = 4;
    localparam int unsigned LANE_W   = 64;
    localparam int unsigned WORD_W   = LANES * LANE_W;
    localparam int unsigned COL_W    = 16;
    localparam int unsigned VAL_W    = 48;
    localparam int unsigned PART_W   = 24;
    localparam int unsigned COUNT_W  = 16;

    // Field offsets inside the 48-bit value and the 64-bit lane
    localparam int unsigned IMAG_LSB = 0;
    localparam int unsigned REAL_LSB = 24;
    localparam int unsigned COL_LSB  = 48;

    // One lane of a Y SRAM word: {col, real, imag}
    typedef struct packed {
        logic [COL_W-1:0]  col;
        logic [PART_W-1:0] realPart;
        logic [PART_W-1:0] imagPart;
    } yLane_t;

    typedef enum logic [2:0] {
        stIdle  = 3'd0,
        stRead  = 3'd1,
        stMerge = 3'd2,
`ifdef Y_WB_COALESCE_EN
        stWrite = 3'd3,
        stEvict = 3'd4
`else
        stWrite = 3'd3
`endif
    } wbState_t;

    // True when exactly one select bit is set
    function automatic logic isOneHot(input logic [LANES-1:0] sel);
        return (sel != '0) && ((sel & (sel - LANES'(1))) == '0);
    endfunction

endpackage

// File: rtl/y_lane_merge.sv
// Replaces the selected 64-bit lane of a 256-bit Y word; purely combinational.
module y_lane_merge
    import y_wb_pkg::*;
(
    input  logic [WORD_W-1:0] word,
    input  logic [LANES-1:0]  onehot,
    input  logic [LANE_W-1:0] lane,
    output logic [WORD_W-1:0] merged_c
);

    // Splice the lane into every selected slot, keep the rest of the word
    always_comb begin
        merged_c = word;
        for (int i = 0; i < int'(LANES); i++) begin
            if (onehot[i]) begin
                merged_c[i*LANE_W +: LANE_W] = lane;
            end
        end
    end

endmodule

// File: rtl/y_writeback_merge.sv
// Read-modify-write stage for Y SRAM lane updates (IDLE -> READ -> MERGE -> WRITE).
// Optional feature macro: Y_WB_COALESCE_EN (one-word coalesce buffer, EVICT state, no WRITE state).
module y_writeback_merge
    import y_wb_pkg::*;
#(
    parameter int unsigned ADDR_W = Y_ADDR_W
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               wb_valid,
    output logic               wb_ready,
    input  logic [ADDR_W-1:0]  wb_addr,
    input  logic [LANES-1:0]   wb_onehot,
    input  logic [COL_W-1:0]   wb_col,
    input  logic [VAL_W-1:0]   wb_val,
    input  logic               flush_req,
    output logic               flush_done,
    output logic               ysram_rd_en,
    output logic [ADDR_W-1:0]  ysram_rd_addr,
    input  logic [WORD_W-1:0]  ysram_rd_data,
    output logic               ysram_wr_en,
    output logic [ADDR_W-1:0]  ysram_wr_addr,
    output logic [WORD_W-1:0]  ysram_wr_data,
    output logic               err_onehot,
    output logic [COUNT_W-1:0] wr_count
);

    wbState_t          state;
    wbState_t          nextState;
    logic              outOfReset;
    logic              flushServed;
    logic [ADDR_W-1:0] capAddr;
    logic [LANES-1:0]  capOnehot;
    yLane_t            capLane;
    logic              transfer;
    logic              acceptGood;
    logic [WORD_W-1:0] mergeBase;
    logic [WORD_W-1:0] mergedWord;
    logic              nextRdEn;
    logic              nextWrEn;
    logic              nextFlushDone;
    logic [ADDR_W-1:0] nextRdAddr;
    logic [ADDR_W-1:0] nextWrAddr;
    logic [WORD_W-1:0] nextWrData;
`ifdef Y_WB_COALESCE_EN
    logic [ADDR_W-1:0] bufAddr;
    logic [WORD_W-1:0] bufData;
    logic              bufDirty;
    logic              bufHit;
    logic              capHit;
    logic              pendValid;
`endif

    assign wb_ready   = outOfReset && (state == stIdle) && !flush_req;
    assign transfer   = wb_valid && wb_ready;
    assign acceptGood = transfer && isOneHot(wb_onehot);

    y_lane_merge uLaneMerge (
        .word     (mergeBase),
        .onehot   (capOnehot),
        .lane     (capLane),
        .merged_c (mergedWord)
    );

    // Next-state and next registered SRAM/status outputs
    always_comb begin
        nextState     = state;
        nextRdEn      = 1'b0;
        nextRdAddr    = ysram_rd_addr;
        nextWrEn      = 1'b0;
        nextWrAddr    = ysram_wr_addr;
        nextWrData    = ysram_wr_data;
        nextFlushDone = 1'b0;
        mergeBase     = ysram_rd_data;
`ifdef Y_WB_COALESCE_EN
        bufHit = bufDirty && (wb_addr == bufAddr);
        if (capHit) begin
            mergeBase = bufData;
        end
`endif
        unique case (state)
            stIdle: begin
`ifdef Y_WB_COALESCE_EN
                if (acceptGood) begin
                    if (bufHit) begin
                        nextState = stMerge;
                    end else if (bufDirty) begin
                        nextState = stEvict;
                    end else begin
                        nextState = stRead;
                    end
                end else if (flush_req && bufDirty) begin
                    nextState = stEvict;
                end else begin
                    nextFlushDone = flush_req && !flushServed;
                end
`else
                if (acceptGood) begin
                    nextState = stRead;
                end else begin
                    nextFlushDone = flush_req && !flushServed;
                end
`endif
            end
            stRead:  nextState = stMerge;
`ifdef Y_WB_COALESCE_EN
            stMerge: nextState = stIdle;
            stEvict: begin
                // A flush-triggered eviction reports done on its way out
                nextState     = pendValid ? stRead : stIdle;
                nextFlushDone = !pendValid && flush_req && !flushServed;
            end
`else
            stMerge: nextState = stWrite;
`endif
            stWrite: nextState = stIdle;
            default: nextState = stIdle;
        endcase

        if (nextState == stRead) begin
            nextRdEn   = 1'b1;
            nextRdAddr = (state == stIdle) ? wb_addr : capAddr;
        end
`ifdef Y_WB_COALESCE_EN
        if (nextState == stEvict) begin
            nextWrEn   = 1'b1;
            nextWrAddr = bufAddr;
            nextWrData = bufData;
        end
`else
        if (nextState == stWrite) begin
            nextWrEn   = 1'b1;
            nextWrAddr = capAddr;
            nextWrData = mergedWord;
        end
`endif
    end

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= stIdle;
        end else begin
            state <= nextState;
        end
    end

    // Registered outputs, write counter and flush edge tracking
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            outOfReset    <= 1'b0;
            flushServed   <= 1'b0;
            ysram_rd_en   <= 1'b0;
            ysram_rd_addr <= '0;
            ysram_wr_en   <= 1'b0;
            ysram_wr_addr <= '0;
            ysram_wr_data <= '0;
            flush_done    <= 1'b0;
            err_onehot    <= 1'b0;
            wr_count      <= '0;
        end else begin
            outOfReset    <= 1'b1;
            ysram_rd_en   <= nextRdEn;
            ysram_rd_addr <= nextRdAddr;
            ysram_wr_en   <= nextWrEn;
            ysram_wr_addr <= nextWrAddr;
            ysram_wr_data <= nextWrData;
            flush_done    <= nextFlushDone;
            err_onehot    <= transfer && !isOneHot(wb_onehot);
            if (nextWrEn && (wr_count != '1)) begin
                wr_count <= wr_count + COUNT_W'(1);
            end
            if (nextFlushDone) begin
                flushServed <= 1'b1;
            end else if (!flush_req) begin
                flushServed <= 1'b0;
            end
        end
    end

    // Capture the accepted entry
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            capAddr   <= '0;
            capOnehot <= '0;
            capLane   <= '0;
        end else if (acceptGood) begin
            capAddr          <= wb_addr;
            capOnehot        <= wb_onehot;
            capLane.col      <= wb_col;
            capLane.realPart <= wb_val[REAL_LSB +: PART_W];
            capLane.imagPart <= wb_val[IMAG_LSB +: PART_W];
        end
    end

`ifdef Y_WB_COALESCE_EN
    // Coalesce buffer: filled by MERGE, drained by EVICT
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            bufAddr   <= '0;
            bufData   <= '0;
            bufDirty  <= 1'b0;
            capHit    <= 1'b0;
            pendValid <= 1'b0;
        end else begin
            if (acceptGood) begin
                capHit    <= bufHit;
                pendValid <= 1'b1;
            end
            if (state == stMerge) begin
                bufData   <= mergedWord;
                bufAddr   <= capAddr;
                bufDirty  <= 1'b1;
                pendValid <= 1'b0;
            end else if (state == stEvict) begin
                bufDirty <= 1'b0;
            end
        end
    end
`endif

endmodule

// File: tb/tb_y_writeback_merge.sv
// Directed self-checking bench for y_writeback_merge (default build, coalesce buffer disabled).
`timescale 1ns/1ps
module tb_y_writeback_merge;

    logic         clock = 1'b0;
    logic         reset;
    logic         wb_valid;
    logic         wb_ready;
    logic [10:0]  wb_addr;
    logic [3:0]   wb_onehot;
    logic [15:0]  wb_col;
    logic [47:0]  wb_val;
    logic         flush_req;
    logic         flush_done;
    logic         ysram_rd_en;
    logic [10:0]  ysram_rd_addr;
    logic [255:0] ysram_rd_data;
    logic         ysram_wr_en;
    logic [10:0]  ysram_wr_addr;
    logic [255:0] ysram_wr_data;
    logic         err_onehot;
    logic [15:0]  wr_count;

    int checks   = 0;
    int failures = 0;
    int rdCnt    = 0;
    int wrCnt    = 0;
    int errCnt   = 0;
    int doneCnt  = 0;

    logic [255:0] mem [0:2047];
    logic [10:0]  wrAddrQ [$];
    logic [255:0] wrDataQ [$];

    y_writeback_merge dut (
        .clock         (clock),
        .reset         (reset),
        .wb_valid      (wb_valid),
        .wb_ready      (wb_ready),
        .wb_addr       (wb_addr),
        .wb_onehot     (wb_onehot),
        .wb_col        (wb_col),
        .wb_val        (wb_val),
        .flush_req     (flush_req),
        .flush_done    (flush_done),
        .ysram_rd_en   (ysram_rd_en),
        .ysram_rd_addr (ysram_rd_addr),
        .ysram_rd_data (ysram_rd_data),
        .ysram_wr_en   (ysram_wr_en),
        .ysram_wr_addr (ysram_wr_addr),
        .ysram_wr_data (ysram_wr_data),
        .err_onehot    (err_onehot),
        .wr_count      (wr_count)
    );

    always #5 clock = ~clock;

    // Y SRAM model with one-cycle read latency, plus event counters
    always @(posedge clock) begin
        if (ysram_rd_en) begin
            ysram_rd_data <= mem[ysram_rd_addr];
            rdCnt <= rdCnt + 1;
        end
        if (ysram_wr_en) begin
            mem[ysram_wr_addr] <= ysram_wr_data;
            wrAddrQ.push_back(ysram_wr_addr);
            wrDataQ.push_back(ysram_wr_data);
            wrCnt <= wrCnt + 1;
        end
        if (err_onehot) errCnt <= errCnt + 1;
        if (flush_done) doneCnt <= doneCnt + 1;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not reach its summary");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [255:0] onesWith(input int lane, input logic [63:0] v);
        logic [255:0] w;
        w = '1;
        w[lane*64 +: 64] = v;
        return w;
    endfunction

    task automatic drive(input logic [10:0] a, input logic [3:0] oh, input logic [15:0] c, input logic [47:0] v);
        wb_addr   = a;
        wb_onehot = oh;
        wb_col    = c;
        wb_val    = v;
    endtask

    logic [10:0] bAddr [3];
    logic [3:0]  bOh   [3];
    int          bLane [3];
    logic [15:0] bCol  [3];
    logic [47:0] bVal  [3];

    initial begin
        int idx;
        int n;
        int rd0, wr0, e0, d0;
        logic xfer;

        for (int i = 0; i < 2048; i++) mem[i] = '1;
        ysram_rd_data = '0;
        bAddr[0] = 11'h100; bOh[0] = 4'b0001; bLane[0] = 0; bCol[0] = 16'h0011; bVal[0] = 48'h123456_ABCDEF;
        bAddr[1] = 11'h101; bOh[1] = 4'b0100; bLane[1] = 2; bCol[1] = 16'h0022; bVal[1] = 48'h800000_7FFFFF;
        bAddr[2] = 11'h102; bOh[2] = 4'b1000; bLane[2] = 3; bCol[2] = 16'h0033; bVal[2] = 48'hFFFFFF_000001;

        reset = 1'b1; wb_valid = 1'b0; flush_req = 1'b0;
        drive(11'h0, 4'h0, 16'h0, 48'h0);
        repeat (3) step();
        check("rst_ready", wb_ready, 1'b0);
        check("rst_rd_en", ysram_rd_en, 1'b0);
        check("rst_wr_en", ysram_wr_en, 1'b0);
        check("rst_wr_count", wr_count, 16'h0);
        check("rst_flush_done", flush_done, 1'b0);
        check("rst_err", err_onehot, 1'b0);
        check("rst_wr_data", ysram_wr_data, 256'h0);
        reset = 1'b0;
        step();
        check("post_rst_ready", wb_ready, 1'b1);

        // Single update into an all-ones word
        drive(11'h005, 4'b0010, 16'h0003, 48'h000100_FFFF00);
        wb_valid = 1'b1;
        step();
        wb_valid = 1'b0;
        check("t1_rd_en", ysram_rd_en, 1'b1);
        check("t1_rd_addr", ysram_rd_addr, 11'h005);
        check("t1_ready_busy", wb_ready, 1'b0);
        step();
        check("t1_rd_en_c2", ysram_rd_en, 1'b0);
        check("t1_wr_en_c2", ysram_wr_en, 1'b0);
        step();
        check("t1_wr_en", ysram_wr_en, 1'b1);
        check("t1_wr_addr", ysram_wr_addr, 11'h005);
        check("t1_wr_data", ysram_wr_data, onesWith(1, 64'h0003_000100_FFFF00));
        check("t1_wr_count", wr_count, 16'd1);
        step();
        check("t1_wr_en_c4", ysram_wr_en, 1'b0);
        check("t1_ready_back", wb_ready, 1'b1);

        // Back-to-back: valid held high for three entries
        wrAddrQ.delete();
        wrDataQ.delete();
        idx = 0;
        drive(bAddr[0], bOh[0], bCol[0], bVal[0]);
        wb_valid = 1'b1;
        for (int k = 0; k < 12; k++) begin
            check($sformatf("b2b_ready_c%0d", k), wb_ready, ((k % 4) == 0) ? 1'b1 : 1'b0);
            xfer = wb_valid && wb_ready;
            step();
            if (xfer) begin
                idx++;
                if (idx < 3) drive(bAddr[idx], bOh[idx], bCol[idx], bVal[idx]);
                else wb_valid = 1'b0;
            end
        end
        check("b2b_nwrites", wrAddrQ.size(), 3);
        for (int i = 0; i < 3; i++) begin
            if (i < wrAddrQ.size()) begin
                check($sformatf("b2b_addr%0d", i), wrAddrQ[i], bAddr[i]);
                check($sformatf("b2b_data%0d", i), wrDataQ[i], onesWith(bLane[i], {bCol[i], bVal[i]}));
            end
        end
        check("b2b_wr_count", wr_count, 16'd4);

        // Non-one-hot selects are dropped with an error pulse
        rd0 = rdCnt; wr0 = wrCnt; e0 = errCnt;
        drive(11'h300, 4'b0000, 16'h1234, 48'h1);
        wb_valid = 1'b1;
        step();
        check("err0_pulse", err_onehot, 1'b1);
        check("err0_ready", wb_ready, 1'b1);
        check("err0_rd_en", ysram_rd_en, 1'b0);
        wb_onehot = 4'b0110;
        step();
        wb_valid = 1'b0;
        check("err1_pulse", err_onehot, 1'b1);
        step();
        check("err_clear", err_onehot, 1'b0);
        repeat (3) step();
        check("err_count", errCnt - e0, 2);
        check("err_no_rd", rdCnt - rd0, 0);
        check("err_no_wr", wrCnt - wr0, 0);
        check("err_wr_count", wr_count, 16'd4);

        // Reset while in MERGE discards the in-flight update
        drive(11'h200, 4'b0001, 16'hAAAA, 48'h0);
        wb_valid = 1'b1;
        step();
        wb_valid = 1'b0;
        step();
        reset = 1'b1;
        #1;
        check("mrst_rd_en", ysram_rd_en, 1'b0);
        check("mrst_wr_en", ysram_wr_en, 1'b0);
        check("mrst_wr_count", wr_count, 16'h0);
        check("mrst_ready", wb_ready, 1'b0);
        check("mrst_wr_data", ysram_wr_data, 256'h0);
        wr0 = wrCnt;
        repeat (2) step();
        reset = 1'b0;
        n = 0;
        while (!wb_ready && n < 10) begin
            step();
            n++;
        end
        check("mrst_ready_back", wb_ready, 1'b1);
        check("mrst_no_write", wrCnt - wr0, 0);
        check("mrst_mem_intact", mem[11'h200], {256{1'b1}});
        drive(11'h201, 4'b1000, 16'h0BEE, 48'h0000FF_FF0000);
        wb_valid = 1'b1;
        step();
        wb_valid = 1'b0;
        repeat (3) step();
        check("mrst_next_nwr", wrCnt - wr0, 1);
        if (wrAddrQ.size() > 0) begin
            check("mrst_next_addr", wrAddrQ[wrAddrQ.size()-1], 11'h201);
            check("mrst_next_data", wrDataQ[wrDataQ.size()-1], onesWith(3, 64'h0BEE_0000FF_FF0000));
        end
        check("mrst_next_count", wr_count, 16'd1);

        // Flush while idle: one done pulse, ready held low
        d0 = doneCnt; rd0 = rdCnt;
        flush_req = 1'b1;
        drive(11'h050, 4'b0001, 16'h0001, 48'h1);
        wb_valid = 1'b1;
        #1;
        check("fl_ready_low", wb_ready, 1'b0);
        step();
        check("fl_done", flush_done, 1'b1);
        step();
        check("fl_done_once", flush_done, 1'b0);
        check("fl_ready_held", wb_ready, 1'b0);
        repeat (3) step();
        check("fl_done_count", doneCnt - d0, 1);
        check("fl_no_rd", rdCnt - rd0, 0);
        wb_valid = 1'b0;
        flush_req = 1'b0;
        #1;
        check("fl_ready_back", wb_ready, 1'b1);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
